// File: rtl/filter_driver.sv
// Drives an 8-vector {X,A,B} sequence into a filter and scores each returned result against a latched expectation.
// Start-to-Done latency is 1 + 8*(SETTLE+3) cycles; Start is ignored until the FSM is back in IDLE.
module filter_driver #(
  parameter int SETTLE = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic [7:0] Expected,
  input  logic       OutResult,
  output logic       X,
  output logic       A,
  output logic       B,
  output logic       Busy,
  output logic       Done,
  output logic [3:0] PassCount,
  output logic [3:0] FailCount
);

  typedef enum logic [2:0] {IDLE, CLEAR, APPLY, HOLD, SAMPLE, FINISH} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic [3:0] hold_cnt, hold_cnt_nxt;
  logic [7:0] exp_q, exp_nxt;
  logic [3:0] pass_nxt, fail_nxt;
  logic [2:0] xab_nxt;
  logic       busy_nxt, done_nxt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      idx       <= 3'd0;
      hold_cnt  <= 4'd0;
      exp_q     <= 8'd0;
      PassCount <= 4'd0;
      FailCount <= 4'd0;
      {X, A, B} <= 3'b100;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      hold_cnt  <= hold_cnt_nxt;
      exp_q     <= exp_nxt;
      PassCount <= pass_nxt;
      FailCount <= fail_nxt;
      {X, A, B} <= xab_nxt;
      Busy      <= busy_nxt;
      Done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    hold_cnt_nxt = hold_cnt;
    exp_nxt      = exp_q;
    pass_nxt     = PassCount;
    fail_nxt     = FailCount;
    case (state)
      IDLE: begin
        if (Start) begin
          exp_nxt   = Expected;
          pass_nxt  = 4'd0;
          fail_nxt  = 4'd0;
          idx_nxt   = 3'd0;
          state_nxt = CLEAR;
        end
      end
      CLEAR: state_nxt = APPLY;
      APPLY: begin
        hold_cnt_nxt = 4'd0;
        state_nxt    = HOLD;
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = SAMPLE;
        end else begin
          hold_cnt_nxt = hold_cnt + 4'd1;
        end
      end
      SAMPLE: begin
        if (OutResult == exp_q[idx]) begin
          pass_nxt = PassCount + 4'd1;
        end else begin
          fail_nxt = FailCount + 4'd1;
        end
        if (idx == 3'd7) begin
          state_nxt = FINISH;
        end else begin
          idx_nxt   = idx + 3'd1;
          state_nxt = CLEAR;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    xab_nxt  = 3'b100;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      CLEAR: busy_nxt = 1'b1;
      APPLY, HOLD, SAMPLE: begin
        xab_nxt  = idx_nxt;
        busy_nxt = 1'b1;
      end
      FINISH:  done_nxt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/filter_driver.md
FILTER_DRIVER -- requirements
Module: filter_driver

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, giving the number of clock cycles (1..15) a vector is held before OutResult is sampled.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port Start, input, 1 bit: a one-cycle request to run the 8-vector sequence.
REQ-005 The block SHALL have port Expected, input, 8 bits: expected OutResult per vector; bit i is for vector i, sampled on the accepted Start.
REQ-006 The block SHALL have port OutResult, input, 1 bit: the result returned by the filter under drive.
REQ-007 The block SHALL have ports X, A and B, outputs, 1 bit each: the stimulus lines to the filter.
REQ-008 The block SHALL have port Busy, output, 1 bit: high while a sequence is in progress.
REQ-009 The block SHALL have port Done, output, 1 bit: a one-cycle pulse when a sequence completes.
REQ-010 The block SHALL have ports PassCount and FailCount, outputs, 4 bits each: the vector compare totals of the last sequence.

Function
REQ-011 The FSM SHALL have states IDLE, CLEAR, APPLY, HOLD, SAMPLE and FINISH.
REQ-012 In IDLE, a cycle with Start=1 SHALL do all of the following on the next edge:
- latch Expected;
- clear PassCount, FailCount and the 3-bit vector index;
- go to CLEAR.
REQ-013 In IDLE, a cycle with Start=0 SHALL keep the FSM in IDLE.
REQ-014 CLEAR SHALL last 1 cycle and drive X=1, A=0, B=0, then go to APPLY.
REQ-015 APPLY SHALL last 1 cycle and drive {X,A,B} equal to the vector index (X is the MSB), then go to HOLD.
REQ-016 HOLD SHALL keep the APPLY drive for exactly SETTLE cycles, counted by a 4-bit counter, then go to SAMPLE.
REQ-017 SAMPLE SHALL last 1 cycle and keep the drive.
REQ-018 In SAMPLE, PassCount SHALL increment if OutResult equals latched Expected[index]; otherwise FailCount SHALL increment.
REQ-019 From SAMPLE, the FSM SHALL go to FINISH if index is 7; otherwise it SHALL increment index and go to CLEAR.
REQ-020 FINISH SHALL last 1 cycle with Done=1 and X=1, A=0, B=0, then go to IDLE.
REQ-021 The latency from Start to Done SHALL be 1 + 8*(SETTLE+3) cycles, i.e. 41 cycles for SETTLE=2.
REQ-022 Busy SHALL be 1 in CLEAR, APPLY, HOLD and SAMPLE, and 0 in IDLE and FINISH.
REQ-023 Start SHALL be ignored while Busy=1 or in FINISH, and Expected changes after acceptance SHALL have no effect.
REQ-024 PassCount+FailCount SHALL equal 8 after Done, so no count overflow occurs.
REQ-025 The counts SHALL hold their values until the next accepted Start.
REQ-026 In IDLE, the outputs SHALL be X=1, A=0, B=0.
REQ-027 All outputs SHALL be registered, with no combinational path from OutResult or Start to any output.

Reset
REQ-028 Rst=1 SHALL force the state to IDLE and X=1, A=0, B=0, Busy=0, Done=0, PassCount=0, FailCount=0, with index and hold counter 0, without waiting for a clock edge.
REQ-029 Rst asserted mid-sequence SHALL abort the sequence with no Done pulse.
REQ-030 After Rst deasserts, the block SHALL wait for a new Start.

Verification
REQ-031 The bench SHALL cover: Start with Expected=8'hFF and OutResult tied 1 -> Done 41 cycles later, PassCount=8, FailCount=0.
REQ-032 The bench SHALL cover: Expected=8'h0F and OutResult tied 1 -> PassCount=4, FailCount=4.
REQ-033 The bench SHALL cover: the stimulus trace over one run -> {X,A,B} steps 0..7, each vector preceded by one CLEAR cycle (1,0,0) and held SETTLE+2 cycles.
REQ-034 The bench SHALL cover: Start pulsed again at cycle 10 of a run -> ignored, with the same Done time and counts as an undisturbed run.
REQ-035 The bench SHALL cover: Rst pulsed at cycle 20 -> immediate IDLE, all outputs at reset values, no Done; a following Start runs a full 41-cycle sequence.
REQ-036 The bench SHALL cover: SETTLE=5 with Start -> Done after 65 cycles, and a Start held high across FINISH not retriggering until IDLE.
